// File: rtl/txuart.sv
// txuart: 8N1 LSB-first UART transmitter with valid/ready input and a one-byte holding register
module txuart #(
    parameter int CLKS_PERBAUD = 50_000_000 / 19200
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_uart_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done
);
    typedef enum logic [1:0] {IDLE, START, DATA_BITS, STOP_BIT} state_t;
    localparam logic [31:0] LAST = 32'(CLKS_PERBAUD - 1);
    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d, hold_q, hold_d;
    logic        hold_full_q, hold_full_d, tx_q, tx_d, busy_q, done_q, done_d;
    logic        accept, last, take_next;
    assign accept     = i_tx_valid & ~hold_full_q;
    assign last       = count_q == LAST;
    assign o_tx_ready = ~hold_full_q;
    assign o_uart_tx  = tx_q;
    assign o_tx_busy  = busy_q;
    assign o_tx_done  = done_q;
    // Bit timing, next-byte selection (holding first, then input) and the registered line level
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        done_d      = 1'b0;
        take_next   = 1'b0;
        case (state_q)
            IDLE: begin
                count_d   = '0;
                take_next = 1'b1;
            end
            START: begin
                count_d = last ? '0 : count_q + 32'd1;
                idx_d   = last ? 3'd0 : idx_q;
                state_d = last ? DATA_BITS : START;
            end
            DATA_BITS: begin
                count_d = last ? '0 : count_q + 32'd1;
                idx_d   = (last && idx_q != 3'd7) ? idx_q + 3'd1 : idx_q;
                state_d = (last && idx_q == 3'd7) ? STOP_BIT : DATA_BITS;
            end
            STOP_BIT: begin
                count_d   = last ? '0 : count_q + 32'd1;
                done_d    = last;
                take_next = last;
                state_d   = last ? IDLE : STOP_BIT;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
        if (take_next && hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = START;
        end else if (take_next && accept) begin
            shift_d = i_tx_byte;
            state_d = START;
        end else if (accept) begin
            hold_d      = i_tx_byte;
            hold_full_d = 1'b1;
        end
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA_BITS) ? shift_d[idx_d] : 1'b1;
    end
    // State and output registers; reset wins over any handshake on the same edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            busy_q      <= state_d != IDLE;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_txuart.sv
// tb_txuart: randomized and directed bench for txuart against a frame-timeline model and a line decoder
module tb_txuart;
    localparam int N = 4;
    logic       clk = 1'b0, rst = 1'b0, valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ready, tx, busy, done;
    int         errs = 0, checks = 0, cyc = 0;
    bit         armed = 1'b0;
    bit         m_busy = 1'b0, m_hold_full = 1'b0, m_done = 1'b0;
    int         m_t = 0;
    logic [7:0] m_byte = 8'h00, m_hold = 8'h00;
    logic [7:0] exp_q[$], rx_log[$];
    int         done_times[$];
    bit         rx_on = 1'b0;
    int         rx_j = 0;
    logic [7:0] rx_b = 8'h00;

    always #5 clk = ~clk;

    txuart #(.CLKS_PERBAUD(N)) dut (
        .i_clk(clk), .i_reset(rst), .i_tx_byte(din), .i_tx_valid(valid),
        .o_tx_ready(ready), .o_uart_tx(tx), .o_tx_busy(busy), .o_tx_done(done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Model: a frame is a 10*N-cycle timeline starting at the edge the byte is taken
    task automatic start_frame(input logic [7:0] b);
        m_busy = 1'b1;
        m_t = 0;
        m_byte = b;
        exp_q.push_back(b);
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [7:0] b);
        bit acc;
        if (r) begin
            m_busy = 1'b0;
            m_hold_full = 1'b0;
            m_done = 1'b0;
            exp_q.delete();
            return;
        end
        acc = v && !m_hold_full;
        m_done = 1'b0;
        if (m_busy) begin
            m_t++;
            if (m_t == 10 * N) begin
                m_done = 1'b1;
                m_busy = 1'b0;
            end
        end
        if (!m_busy) begin
            if (m_hold_full) begin
                start_frame(m_hold);
                m_hold_full = 1'b0;
            end else if (acc) begin
                start_frame(b);
                acc = 1'b0;
            end
        end
        if (acc) begin
            m_hold = b;
            m_hold_full = 1'b1;
        end
    endtask

    function automatic logic m_line();
        int k;
        if (!m_busy) return 1'b1;
        k = m_t / N;
        return (k == 0) ? 1'b0 : (k <= 8) ? m_byte[k-1] : 1'b1;
    endfunction

    task automatic drive(input bit r, input bit v, input logic [7:0] b);
        @(negedge clk);
        rst = r;
        valid = v;
        din = b;
        @(posedge clk);
        model_edge(r, v, b);
        cyc++;
        #1;
        if (done === 1'b1) done_times.push_back(cyc);
    endtask

    task automatic send(input logic [7:0] b);
        bit r;
        for (int n = 0; n < 200; n++) begin
            r = ready;
            drive(0, 1, b);
            if (r) return;
        end
        errs++;
        checks++;
        $display("FAIL send_timeout byte %0h: ready stayed 0, expected 1", b);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 600; n++) begin
            if (!busy && ready) return;
            drive(0, 0, 8'($urandom));
        end
        errs++;
        checks++;
        $display("FAIL idle_timeout: busy=%0b ready=%0b, expected busy=0 ready=1", busy, ready);
    endtask

    // Compare process plus a mid-bit line decoder
    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("tx", tx, m_line());
            chk("ready", ready, !m_hold_full);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (!m_busy) rx_on = 1'b0;
            if (rx_on) begin
                rx_j++;
                if (rx_j % N == N / 2 && rx_j / N >= 1 && rx_j / N <= 8) rx_b[rx_j/N-1] = tx;
                if (rx_j == 9 * N + N / 2) begin
                    chk("stop_bit", tx, 1'b1);
                    rx_log.push_back(rx_b);
                    if (exp_q.size() == 0) chk("rx_unexpected", rx_b, 8'hxx);
                    else chk("rx_byte", rx_b, exp_q.pop_front());
                    rx_on = 1'b0;
                end
            end else if (tx === 1'b0) begin
                rx_on = 1'b1;
                rx_j = 0;
            end
        end
    end

    initial begin
        logic [9:0] cells;
        logic [7:0] lb [5];
        int low;
        lb = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h81};
        drive(1, 0, 8'h00);
        armed = 1'b1;
        drive(1, 0, 8'h00);
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        while (cyc < 9) drive(0, 0, 8'($urandom));
        done_times.delete();
        cells = '0;
        low = 0;
        for (int o = 0; o < 46; o++) begin
            drive(0, o == 0, o == 0 ? 8'hA5 : 8'($urandom));
            if (o < 40 && o % N == N / 2) cells[o/N] = tx;
            if (!ready) low++;
        end
        chk("a5_frame", cells, 10'h34A);
        chk("a5_done_count", done_times.size(), 1);
        if (done_times.size() > 0) chk("a5_done_cycle", done_times[0] + 1, 51);
        chk("a5_ready_low", low, 0);
        chk("a5_busy_after", busy, 1'b0);

        done_times.delete();
        rx_log.delete();
        send(8'h00);
        drive(0, 1, 8'hFF);
        low = 0;
        for (int n = 0; n < 100 && !ready; n++) begin
            low++;
            drive(0, 1, 8'($urandom));
        end
        chk("ready_low_cycles", low, 39);
        send(8'h3C);
        wait_idle();
        chk("b2b_done_count", done_times.size(), 3);
        if (done_times.size() == 3) begin
            chk("b2b_gap1", done_times[1] - done_times[0], 40);
            chk("b2b_gap2", done_times[2] - done_times[1], 40);
        end
        chk("b2b_rx_count", rx_log.size(), 3);
        if (rx_log.size() == 3) begin
            chk("b2b_rx0", rx_log[0], 8'h00);
            chk("b2b_rx1", rx_log[1], 8'hFF);
            chk("b2b_rx2", rx_log[2], 8'h3C);
        end

        rx_log.delete();
        foreach (lb[i]) send(lb[i]);
        wait_idle();
        chk("loop_count", rx_log.size(), 5);
        if (rx_log.size() == 5) foreach (lb[i]) chk("loop_byte", rx_log[i], lb[i]);

        rx_log.delete();
        for (int i = 0; i < 40; i++) begin
            for (int g = $urandom_range(0, 3) * ($urandom_range(0, 1)); g > 0; g--) drive(0, 0, 8'($urandom));
            send(8'($urandom));
        end
        wait_idle();
        chk("rand_count", rx_log.size(), 40);

        done_times.delete();
        rx_log.delete();
        send(8'h99);
        send(8'h66);
        repeat (18) drive(0, 0, 8'($urandom));
        drive(1, 0, 8'h00);
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        repeat (100) drive(0, 0, 8'($urandom));
        chk("midrst_done", done_times.size(), 0);
        chk("midrst_rx", rx_log.size(), 0);

        drive(1, 1, 8'h5A);
        chk("rstvalid_busy", busy, 1'b0);
        chk("rstvalid_ready", ready, 1'b1);
        chk("rstvalid_tx", tx, 1'b1);
        repeat (50) drive(0, 0, 8'($urandom));
        chk("rstvalid_rx", rx_log.size(), 0);
        chk("rstvalid_done", done_times.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
